mem_arbiter: RTL
================

MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Parameter TIMEOUT, default 15, is the number of BUSY cycles without mem_ready before a transaction is aborted; legal range 1..255.
REQ-002 clk  input  1  clock; all state updates on the rising edge.
REQ-003 reset  input  1  reset, asynchronous, active-low.
REQ-004 r0_rd  input  1  requester 0 (instruction-cache controller) read request, level, held until r0_done or r0_err.
REQ-005 r0_wr  input  1  requester 0 write request, level, held until r0_done or r0_err.
REQ-006 r0_addr  input  10  requester 0 word address.
REQ-007 r0_wdata  input  32  requester 0 write data.
REQ-008 r0_done  output  1  one-cycle pulse: requester 0 transaction completed.
REQ-009 r1_rd  input  1  requester 1 (data-cache controller) read request, same rules as r0_rd.
REQ-010 r1_wr  input  1  requester 1 write request.
REQ-011 r1_addr  input  10  requester 1 word address.
REQ-012 r1_wdata  input  32  requester 1 write data.
REQ-013 r1_done  output  1  one-cycle pulse: requester 1 transaction completed.
REQ-014 rdata  output  32  read data, shared; valid while the matching done pulse is high.
REQ-015 err  output  1  one-cycle pulse: granted transaction timed out; qualified by grant.
REQ-016 grant  output  1  index of the requester currently or last served.
REQ-017 mem_rd  output  1  main-memory read strobe, held for the whole access.
REQ-018 mem_wr  output  1  main-memory write strobe, held for the whole access.
REQ-019 mem_addr  output  10  latched address of the granted request.
REQ-020 mem_wdata  output  32  latched write data of the granted request.
REQ-021 mem_rdata  input  32  main-memory read data, valid when mem_ready is high.
REQ-022 mem_ready  input  1  main-memory completion, sampled only in BUSY.

Function
REQ-023 The FSM SHALL have three states: IDLE, BUSY and DONE. All outputs SHALL be registered or decoded from state only.
REQ-024 In IDLE, when any request is high, the arbiter SHALL select a winner at the edge and latch its address, wdata and operation. It SHALL then enter BUSY on the next cycle with mem_rd or mem_wr high.
REQ-025 If one requester asserts both rd and wr, the request SHALL be treated as a write only.
REQ-026 In BUSY, mem_rd/mem_wr, mem_addr and mem_wdata SHALL be held stable. An 8-bit wait counter SHALL be cleared on entry and increment each cycle mem_ready is low.
REQ-027 When mem_ready is sampled high in BUSY:
  - rdata SHALL capture mem_rdata (reads only; rdata is unchanged on writes).
  - The FSM SHALL enter DONE and pulse the winner's done for exactly one cycle.
REQ-028 When the wait counter reaches TIMEOUT-1 with mem_ready low, the FSM SHALL enter DONE and pulse err instead of done. If mem_ready and timeout occur in the same cycle, mem_ready SHALL win.
REQ-029 In DONE, mem_rd and mem_wr SHALL be low. The FSM SHALL return to IDLE unconditionally after one cycle, so requesters have one cycle to drop their request.
REQ-030 Latency:
  - Request high before edge N with the arbiter in IDLE gives mem strobe from cycle N+1.
  - mem_ready sampled at edge M gives done in cycle M+1.
  - Minimum request-to-done latency is 2 cycles.
REQ-031 A request arriving while BUSY or DONE SHALL wait, and SHALL be arbitrated at the next IDLE edge.

Reset
REQ-032 While reset is low: state=IDLE; counter=0; grant=0; rdata=0; mem_addr=0; mem_wdata=0; all strobes, done and err low. Outputs SHALL clear immediately (asynchronously), including mid-transaction.
REQ-033 After reset deasserts, the first arbitration SHALL occur at the first rising edge with reset high.

Configuration
REQ-034 With ARB_ROUND_ROBIN_EN defined, a simultaneous tie SHALL go to the requester not equal to grant (the last-served requester).
REQ-035 Without ARB_ROUND_ROBIN_EN, requester 1 SHALL always win ties (fixed priority).

Verification
REQ-036 Scenario: r0_rd, addr 0x155; mem_ready high on the 3rd BUSY cycle with mem_rdata 0xDEADBEEF. Required: mem_rd high for 3 cycles, mem_addr=0x155, r0_done one cycle, rdata=0xDEADBEEF, grant=0.
REQ-037 Scenario: r1_wr, addr 0x3FF, wdata 0x12345678; mem_ready on the 1st BUSY cycle. Required: mem_wr for 1 cycle, r1_done 2 cycles after the request edge, rdata unchanged.
REQ-038 Scenario: r0_rd and r1_rd held together for 4 transactions. Required with the macro: grant sequence 1,0,1,0. Required without the macro: 1,1,1,1.
REQ-039 Scenario: TIMEOUT=4, mem_ready never asserted. Required: mem_rd for 4 cycles, then err pulse with the winner's grant, no done, return to IDLE.
REQ-040 Scenario: reset driven low mid-BUSY. Required: mem_rd/mem_wr drop within the same cycle without a clock edge; no done/err; clean read served after release.

Source files
------------

// File: rtl/mem_arbiter_if.sv
// Bus bundle between the two cache controllers, the arbiter and main memory.
// The arbiter connects through the slave modport; the requester/memory side uses master.
interface mem_arbiter_if;
    logic        r0_rd;
    logic        r0_wr;
    logic [9:0]  r0_addr;
    logic [31:0] r0_wdata;
    logic        r0_done;
    logic        r1_rd;
    logic        r1_wr;
    logic [9:0]  r1_addr;
    logic [31:0] r1_wdata;
    logic        r1_done;
    logic [31:0] rdata;
    logic        err;
    logic        grant;
    logic        mem_rd;
    logic        mem_wr;
    logic [9:0]  mem_addr;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;
    logic        mem_ready;

    modport slave (
        input  r0_rd, r0_wr, r0_addr, r0_wdata, r1_rd, r1_wr, r1_addr, r1_wdata,
               mem_rdata, mem_ready,
        output r0_done, r1_done, rdata, err, grant, mem_rd, mem_wr, mem_addr, mem_wdata
    );

    modport master (
        output r0_rd, r0_wr, r0_addr, r0_wdata, r1_rd, r1_wr, r1_addr, r1_wdata,
               mem_rdata, mem_ready,
        input  r0_done, r1_done, rdata, err, grant, mem_rd, mem_wr, mem_addr, mem_wdata
    );
endinterface

// File: rtl/mem_arbiter.sv
// Two-requester main-memory arbiter with IDLE/BUSY/DONE sequencing and a wait timeout.
// Define ARB_ROUND_ROBIN_EN to alternate ties; otherwise requester 1 wins ties.
module mem_arbiter #(
    parameter int TIMEOUT = 15
) (
    input  logic          clk,
    input  logic          reset,
    mem_arbiter_if.slave  bus
);
    typedef enum logic [1:0] {
        IDLE = 2'b00,
        BUSY = 2'b01,
        DONE = 2'b10
    } state_t;

    localparam logic [7:0] WAIT_LAST = 8'(TIMEOUT - 1);

    state_t      state_r;
    state_t      next_state_s;
    logic [7:0]  wait_cnt_r;
    logic        grant_r;
    logic        mem_rd_r;
    logic        mem_wr_r;
    logic        done0_r;
    logic        done1_r;
    logic        err_r;
    logic [9:0]  mem_addr_r;
    logic [31:0] mem_wdata_r;
    logic [31:0] rdata_r;

    logic        req0_s;
    logic        req1_s;
    logic        win_s;
    logic        win_wr_s;
    logic [9:0]  win_addr_s;
    logic [31:0] win_wdata_s;
    logic        wait_last_s;

    // Winner selection and the winner's request fields (rd+wr together means write).
    always_comb begin
        req0_s      = bus.r0_rd | bus.r0_wr;
        req1_s      = bus.r1_rd | bus.r1_wr;
        win_s       = 1'b0;
        win_wr_s    = 1'b0;
        win_addr_s  = 10'd0;
        win_wdata_s = 32'd0;
        wait_last_s = (wait_cnt_r == WAIT_LAST);
        if (req0_s && req1_s) begin
`ifdef ARB_ROUND_ROBIN_EN
            win_s = ~grant_r;
`else
            win_s = 1'b1;
`endif
        end else if (req1_s) begin
            win_s = 1'b1;
        end else begin
            win_s = 1'b0;
        end
        if (win_s) begin
            win_wr_s    = bus.r1_wr;
            win_addr_s  = bus.r1_addr;
            win_wdata_s = bus.r1_wdata;
        end else begin
            win_wr_s    = bus.r0_wr;
            win_addr_s  = bus.r0_addr;
            win_wdata_s = bus.r0_wdata;
        end
    end

    // State register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_r <= IDLE;
        end else begin
            state_r <= next_state_s;
        end
    end

    // Next-state decode; mem_ready takes precedence over the timeout.
    always_comb begin
        next_state_s = state_r;
        case (state_r)
            IDLE: begin
                if (req0_s || req1_s) begin
                    next_state_s = BUSY;
                end else begin
                    next_state_s = IDLE;
                end
            end
            BUSY: begin
                if (bus.mem_ready || wait_last_s) begin
                    next_state_s = DONE;
                end else begin
                    next_state_s = BUSY;
                end
            end
            DONE:    next_state_s = IDLE;
            default: next_state_s = IDLE;
        endcase
    end

    // Registered datapath: request latch, wait counter, strobes and completion pulses.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wait_cnt_r  <= 8'd0;
            grant_r     <= 1'b0;
            mem_rd_r    <= 1'b0;
            mem_wr_r    <= 1'b0;
            done0_r     <= 1'b0;
            done1_r     <= 1'b0;
            err_r       <= 1'b0;
            mem_addr_r  <= 10'd0;
            mem_wdata_r <= 32'd0;
            rdata_r     <= 32'd0;
        end else begin
            done0_r <= 1'b0;
            done1_r <= 1'b0;
            err_r   <= 1'b0;
            case (state_r)
                IDLE: begin
                    if (req0_s || req1_s) begin
                        grant_r     <= win_s;
                        mem_addr_r  <= win_addr_s;
                        mem_wdata_r <= win_wdata_s;
                        mem_wr_r    <= win_wr_s;
                        mem_rd_r    <= ~win_wr_s;
                        wait_cnt_r  <= 8'd0;
                    end
                end
                BUSY: begin
                    if (bus.mem_ready) begin
                        mem_rd_r <= 1'b0;
                        mem_wr_r <= 1'b0;
                        done0_r  <= ~grant_r;
                        done1_r  <= grant_r;
                        if (mem_rd_r) begin
                            rdata_r <= bus.mem_rdata;
                        end
                    end else if (wait_last_s) begin
                        mem_rd_r <= 1'b0;
                        mem_wr_r <= 1'b0;
                        err_r    <= 1'b1;
                    end else begin
                        wait_cnt_r <= wait_cnt_r + 8'd1;
                    end
                end
                DONE: begin
                    mem_rd_r <= 1'b0;
                    mem_wr_r <= 1'b0;
                end
                default: begin
                    mem_rd_r <= 1'b0;
                    mem_wr_r <= 1'b0;
                end
            endcase
        end
    end

    assign bus.r0_done   = done0_r;
    assign bus.r1_done   = done1_r;
    assign bus.err       = err_r;
    assign bus.grant     = grant_r;
    assign bus.rdata     = rdata_r;
    assign bus.mem_rd    = mem_rd_r;
    assign bus.mem_wr    = mem_wr_r;
    assign bus.mem_addr  = mem_addr_r;
    assign bus.mem_wdata = mem_wdata_r;
endmodule
